// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through the
// xmitH / xmitdataH / xmitdoneH launch handshake.
//
// Optional feature macro: UART_TXFIFO_OVF_EN
//   defined   -> sticky overflowH flag, set by a write while full,
//                cleared by clrovfH (set wins over clear)
//   undefined -> overflowH tied low, clrovfH ignored
//
// Handshake: when the FSM is IDLE, data is stored and xmitdoneH=1, one
// byte is popped into xmitdataH. The FSM then raises xmitH for exactly
// one cycle (LAUNCH). It waits for xmitdoneH to drop (WAIT_BUSY), then
// for it to rise again (WAIT_DONE), before returning to IDLE.
// xmitdataH stays stable from the pop until the next pop.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sysclk,
    input  logic                  sysrstl,
    input  logic                  wrH,
    input  logic [7:0]            wrdataH,
    output logic                  fullH,
    output logic                  emptyH,
    output logic [DEPTH_LOG2:0]   countH,
    output logic                  xmitH,
    output logic [7:0]            xmitdataH,
    input  logic                  xmitdoneH,
    input  logic                  clrovfH,
    output logic                  overflowH,
    output logic [1:0]            o_dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] C_ZERO = '0;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]            r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [7:0]            r_xmitdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Flags come straight from the registered count, so a write reject is
    // decided on the count before any same-cycle pop.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == C_ZERO);
    assign w_push  = wrH & ~w_full;
    assign w_pop   = (r_state == IDLE) & ~w_empty & xmitdoneH;

    assign fullH       = w_full;
    assign emptyH      = w_empty;
    assign countH      = r_count;
    assign xmitH       = (r_state == LAUNCH);
    assign xmitdataH   = r_xmitdata;
    assign o_dbg_state = r_state;

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wrdataH;
        end
    end

    // Pointers and count; push and pop together leave the count unchanged.
    always_ff @(posedge sysclk) begin
        if (!sysrstl) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output byte register: loaded only on the IDLE->LAUNCH edge.
    always_ff @(posedge sysclk) begin
        if (!sysrstl) begin
            r_xmitdata <= 8'h00;
        end else if (w_pop) begin
            r_xmitdata <= r_mem[r_rptr];
        end
    end

    // Launch FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_pop)      w_state_nxt = LAUNCH;
            LAUNCH:                    w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!xmitdoneH) w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (xmitdoneH)  w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Launch FSM state register.
    always_ff @(posedge sysclk) begin
        if (!sysrstl) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef UART_TXFIFO_OVF_EN
    logic r_overflow;

    // Sticky overflow: a rejected write sets it, clrovfH clears, set wins.
    always_ff @(posedge sysclk) begin
        if (!sysrstl) begin
            r_overflow <= 1'b0;
        end else if (wrH & w_full) begin
            r_overflow <= 1'b1;
        end else if (clrovfH) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflowH = r_overflow;
`else
    logic w_unused_clrovf;

    assign w_unused_clrovf = clrovfH;
    assign overflowH       = 1'b0;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer placed directly upstream of the UART transmitter. It accepts bytes from the host side, stores up to 2^DEPTH_LOG2 of them, and feeds them one at a time into the transmitter's `xmitH`/`xmitdataH`/`xmitdoneH` handshake. This keeps the serial line busy back-to-back without the host tracking frame timing.

## Interface
- `DEPTH_LOG2`, default 4: log2 of storage depth (16 entries); legal range 2..8.
- `sysclk` in 1: single clock; all state changes on its rising edge.
- `sysrstl` in 1: reset; one clock, reset is synchronous and active-low.
- `wrH` in 1: host write strobe; a byte is accepted on an edge where `wrH=1` and `fullH=0`.
- `wrdataH` in 8: host byte, sampled with `wrH`.
- `fullH` out 1: count equals depth.
- `emptyH` out 1: count equals 0.
- `countH` out DEPTH_LOG2+1: stored-byte count, 0..2^DEPTH_LOG2.
- `xmitH` out 1: one-cycle launch pulse to the transmitter.
- `xmitdataH` out 8: byte presented to the transmitter; held stable from launch until the frame completes.
- `xmitdoneH` in 1: transmitter done/idle flag (registered; high while the transmitter is idle).
- `clrovfH` in 1: clears `overflowH` (see Configuration).
- `overflowH` out 1: sticky write-while-full flag (see Configuration).

## Operation
- Storage is a circular buffer with write pointer, read pointer (DEPTH_LOG2 bits each, natural wrap at 2^DEPTH_LOG2) and a separate count register.
- Write: `wrH & ~fullH` stores `wrdataH` at the write pointer, increments the write pointer and increments the count.
- A write while full is discarded. Pointers, count and stored data are unchanged.
- Launch FSM, 4 states, reset state IDLE:
  - IDLE: if `~emptyH & xmitdoneH`, go to LAUNCH. On that edge, load `xmitdataH` from the read pointer, increment the read pointer and decrement the count (pop). Otherwise stay.
  - LAUNCH: `xmitH=1` for this cycle only. Go unconditionally to WAIT_BUSY.
  - WAIT_BUSY: stay while `xmitdoneH=1`. Go to WAIT_DONE when `xmitdoneH=0`.
  - WAIT_DONE: stay while `xmitdoneH=0`. Go to IDLE when `xmitdoneH=1`.
- `xmitH` is 0 in every state except LAUNCH.
- `xmitdataH` changes only on the IDLE→LAUNCH edge.
- Simultaneous push and pop in the same cycle (including at count=1): pointers both advance and the count is unchanged.
- Full plus a pop in the same cycle: the write is still rejected, because `fullH` is evaluated on the current count. The following write succeeds.
- Empty plus a write: the byte is not launched in the same cycle. It is launchable on the next cycle, once `emptyH=0`.
- Reset, including mid-frame: pointers, count and FSM return to IDLE. The buffer contents become don't-care.

## Timing
- Reset values: `fullH=0`, `emptyH=1`, `countH=0`, `xmitH=0`, `xmitdataH=8'h00`, `overflowH=0`.
- Flags and count are registered: they reflect a write or pop on the cycle after the edge.
- Launch latency: a write into an empty FIFO with the transmitter idle gives `xmitH=1` two cycles after the write edge (count update, then the IDLE→LAUNCH edge).
- The transmitter samples `xmitH` at the end of LAUNCH. `xmitdoneH` falls on the following cycle, so WAIT_BUSY lasts 1 cycle nominally.
- Back-to-back: `xmitdoneH` rising → WAIT_DONE→IDLE (1 edge) → IDLE→LAUNCH (1 edge). The next `xmitH` arrives 2 cycles after `xmitdoneH` rises.
- After reset, no launch occurs until the transmitter raises `xmitdoneH`.

## Configuration
- `UART_TXFIFO_OVF_EN` defined:
  - A rejected write (`wrH & fullH`) sets `overflowH=1` on the next edge.
  - `clrovfH=1` clears it to 0.
  - If set and clear coincide, set wins.
- Not defined: `overflowH` is tied to 0, `clrovfH` is ignored and no overflow register is built.

## Test plan
- Reset: hold `sysrstl=0` for 3 cycles during a frame → `emptyH=1`, `countH=0`, `xmitH=0`, `xmitdataH=8'h00`, FSM in IDLE. No further launch until `xmitdoneH=1`.
- Single byte: write 8'hA5 with `xmitdoneH=1` → one `xmitH` pulse 2 cycles later, `xmitdataH=8'hA5` stable until `xmitdoneH` falls and rises again, `countH` returns to 0.
- Burst: write 8'h01..8'h10 (16 bytes, DEPTH_LOG2=4) → `fullH=1` after the 16th write. Launches occur in order 01..10, one per done cycle. `emptyH=1` at the end.
- Overflow, with `UART_TXFIFO_OVF_EN`: 17th write of 8'hFF while full → byte dropped, `countH` stays 16, `overflowH=1`. Pulse `clrovfH` → `overflowH=0`. Without the macro, `overflowH` stays 0.
- Simultaneous push/pop: at `countH=1`, write on the IDLE→LAUNCH edge → `countH` stays 1 and pointers wrap correctly after 20 such cycles.
- Stalled transmitter: hold `xmitdoneH=0` after a launch → FSM stays in WAIT_DONE, no further `xmitH`, writes continue filling the buffer.
